// File: rtl/alsu_sched.sv
// alsu_sched: shares one ALSU among N_REQ requesters and returns id-tagged results.
// Define ALSU_SCHED_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module alsu_sched #(
  parameter int N_REQ    = 2,
  parameter int ALSU_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [16*N_REQ-1:0]   req_cmd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic signed [5:0]     resp_data,
  output logic                  resp_err,
  output logic                  busy,
  output logic signed [2:0]     alsu_A,
  output logic signed [2:0]     alsu_B,
  output logic [2:0]            alsu_opcode,
  output logic                  alsu_cin,
  output logic                  alsu_serial_in,
  output logic                  alsu_red_op_A,
  output logic                  alsu_red_op_B,
  output logic                  alsu_bypass_A,
  output logic                  alsu_bypass_B,
  output logic                  alsu_direction,
  input  logic signed [5:0]     alsu_out,
  input  logic [15:0]           alsu_leds
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [15:0] cmd_q;
  logic [1:0]  id_q;
  logic [2:0]  cnt_q;
  logic        respValid_q;
  logic [1:0]  respId_q;
  logic [5:0]  respData_q;
  logic        respErr_q;

  logic        anyGnt;
  logic [1:0]  gntIdx;
  logic [15:0] gntCmd;

`ifdef ALSU_SCHED_FIXED_PRIO_EN
  always_comb begin
    anyGnt = 1'b0;
    gntIdx = '0;
    gntCmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!anyGnt && req_valid[i]) begin
        anyGnt = 1'b1;
        gntIdx = 2'(i);
        gntCmd = req_cmd[i*16 +: 16];
      end
    end
  end
`else
  logic [1:0] rrPtr_q;
  logic [1:0] rrPtr_d;

  // rrPtr_q is where the next search starts; the first valid line at or after it wins.
  always_comb begin
    anyGnt = 1'b0;
    gntIdx = '0;
    gntCmd = '0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!anyGnt && req_valid[j] && ((int'(rrPtr_q) + off) % N_REQ) == j) begin
          anyGnt = 1'b1;
          gntIdx = 2'(j);
          gntCmd = req_cmd[j*16 +: 16];
        end
      end
    end
  end

  always_comb begin
    rrPtr_d = (int'(gntIdx) == N_REQ - 1) ? 2'd0 : gntIdx + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_q <= '0;
    end else if (state_q == IDLE && anyGnt) begin
      rrPtr_q <= rrPtr_d;
    end
  end
`endif

  // The accept pulse has to land in the grant cycle itself, so it stays combinational.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == IDLE) && !rst && anyGnt && (gntIdx == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      respValid_q <= 1'b0;
      respId_q    <= '0;
      respData_q  <= '0;
      respErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyGnt) begin
            cmd_q   <= gntCmd;
            id_q    <= gntIdx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_q   <= '0;
          cnt_q   <= 3'(ALSU_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            respData_q  <= alsu_out;
            respErr_q   <= |alsu_leds;
            respId_q    <= id_q;
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            respValid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // cmd_q is only nonzero during ISSUE, which gives the all-zero idle pattern elsewhere.
  assign alsu_A         = cmd_q[15:13];
  assign alsu_B         = cmd_q[12:10];
  assign alsu_opcode    = cmd_q[9:7];
  assign alsu_cin       = cmd_q[6];
  assign alsu_serial_in = cmd_q[5];
  assign alsu_red_op_A  = cmd_q[4];
  assign alsu_red_op_B  = cmd_q[3];
  assign alsu_bypass_A  = cmd_q[2];
  assign alsu_bypass_B  = cmd_q[1];
  assign alsu_direction = cmd_q[0];

  assign resp_valid = respValid_q;
  assign resp_id    = respId_q;
  assign resp_data  = respData_q;
  assign resp_err   = respErr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alsu_sched.sv
// tb_alsu_sched: directed bench for alsu_sched with a transaction-level model and a stand-in ALSU.
// Honours ALSU_SCHED_FIXED_PRIO_EN the same way the design does.
module tb_alsu_sched;

  localparam int N_REQ    = 2;
  localparam int ALSU_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_cmd;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [5:0]  resp_data;
  logic        resp_err;
  logic        busy;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic        alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic        alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;

  always #5 clk = ~clk;

  alsu_sched #(.N_REQ(N_REQ), .ALSU_LAT(ALSU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_direction(alsu_direction),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds)
  );

  int totalCnt = 0;
  int badCnt   = 0;
  int cyc      = 0;
  bit checkEn  = 1'b0;
  int gntLog[$];
  int gntCyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALSU: 2 add, 3 signed multiply, 6/7 invalid (leds all ones, out 0), others A^B.
  function automatic logic [6:0] aluFn(input logic [15:0] cmd);
    logic signed [2:0] a;
    logic signed [2:0] b;
    int r;
    a = cmd[15:13];
    b = cmd[12:10];
    case (cmd[9:7])
      3'd2:       r = int'(a) + int'(b) + int'(cmd[6]);
      3'd3:       r = int'(a) * int'(b);
      3'd6, 3'd7: return {1'b1, 6'd0};
      default:    r = int'(a ^ b);
    endcase
    return {1'b0, 6'(r)};
  endfunction

  function automatic logic [15:0] mkCmd(input int a, input int b, input int op);
    logic [15:0] c;
    c = '0;
    c[15:13] = 3'(a);
    c[12:10] = 3'(b);
    c[9:7]   = 3'(op);
    return c;
  endfunction

  logic [15:0] alsuBus;
  logic [6:0]  alsuPipe [ALSU_LAT];
  assign alsuBus = {alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_red_op_A,
                    alsu_red_op_B, alsu_bypass_A, alsu_bypass_B, alsu_direction};

  initial for (int k = 0; k < ALSU_LAT; k++) alsuPipe[k] = '0;

  always @(posedge clk) begin
    alsuPipe[0] <= aluFn(alsuBus);
    for (int k = 1; k < ALSU_LAT; k++) alsuPipe[k] <= alsuPipe[k-1];
  end

  assign alsu_out  = alsuPipe[ALSU_LAT-1][5:0];
  assign alsu_leds = alsuPipe[ALSU_LAT-1][6] ? 16'hFFFF : 16'h0000;

  // Model: an op is "age" cycles past its grant; age 1 is the issue cycle, 2+LAT is the response.
  bit          mActive   = 1'b0;
  int          mAge      = 0;
  int          mPtr      = 0;
  int          mId       = 0;
  logic [15:0] mCmd      = '0;
  logic [1:0]  mRespId   = '0;
  logic [5:0]  mRespData = '0;
  logic        mRespErr  = 1'b0;
  int          mPick;
  logic [1:0]  expRdy;

  function automatic int pick(input logic [1:0] v, input int ptr);
`ifdef ALSU_SCHED_FIXED_PRIO_EN
    for (int j = 0; j < N_REQ; j++) if (v[j]) return j;
`else
    for (int off = 0; off < N_REQ; off++) begin
      int j = (ptr + off) % N_REQ;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  assign mPick  = pick(req_valid, mPtr);
  assign expRdy = (!mActive && !rst && mPick >= 0) ? 2'(1 << mPick) : 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      mActive   <= 1'b0;
      mAge      <= 0;
      mPtr      <= 0;
      mId       <= 0;
      mCmd      <= '0;
      mRespId   <= '0;
      mRespData <= '0;
      mRespErr  <= 1'b0;
    end else if (!mActive) begin
      if (mPick >= 0) begin
        mActive <= 1'b1;
        mAge    <= 1;
        mId     <= mPick;
        mCmd    <= req_cmd[16*mPick +: 16];
        mPtr    <= (mPick + 1) % N_REQ;
      end
    end else if (mAge < 2 + ALSU_LAT) begin
      if (mAge == 1 + ALSU_LAT) begin
        {mRespErr, mRespData} <= aluFn(mCmd);
        mRespId <= 2'(mId);
      end
      mAge <= mAge + 1;
    end else if (resp_ready) begin
      mActive <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("req_ready", 32'(req_ready), 32'(expRdy));
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("resp_valid", 32'(resp_valid), 32'(mActive && mAge == 2 + ALSU_LAT));
      checkOutput("resp_id", 32'(resp_id), 32'(mRespId));
      checkOutput("resp_data", 32'(resp_data), 32'(mRespData));
      checkOutput("resp_err", 32'(resp_err), 32'(mRespErr));
      checkOutput("alsu_bus", 32'(alsuBus), 32'((mActive && mAge == 1) ? mCmd : 16'h0000));
    end
  end

  always @(negedge clk) begin
    if (checkEn && req_ready != 2'b00) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req_ready[j]) begin
          gntLog.push_back(j);
          gntCyc.push_back(cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [15:0] c0, input logic [15:0] c1,
                               input logic rr);
    req_valid  = v;
    req_cmd    = {c1, c0};
    resp_ready = rr;
  endtask

  // Returns just after the grant edge, i.e. in the issue cycle.
  task automatic waitGrant(input int idx);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("grant_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Called in the issue cycle; returns at the negedge of the first response cycle.
  task automatic finishOp(input logic [5:0] expData, input logic expErr, input logic [1:0] expId);
    bit found;
    int lat;
    found = 1'b0;
    lat   = 0;
    applyStimulus(2'b00, req_cmd[15:0], req_cmd[31:16], resp_ready);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        found = 1'b1;
        lat   = k + 1;
        break;
      end
    end
    checkOutput("resp_seen", 32'(found), 32'd1);
    checkOutput("resp_latency", 32'(lat), 32'(2 + ALSU_LAT));
    checkOutput("lit_data", 32'(resp_data), 32'(expData));
    checkOutput("lit_err", 32'(resp_err), 32'(expErr));
    checkOutput("lit_id", 32'(resp_id), 32'(expId));
  endtask

  initial begin
    int expOrder[4];
    int relCyc;
    bit found;
`ifdef ALSU_SCHED_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0};
`else
    expOrder = '{0, 1, 0, 1};
`endif
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkEn = 1'b1;

    // add 3+2 from requester 0
    applyStimulus(2'b01, mkCmd(3, 2, 2), 16'h0, 1'b1);
    waitGrant(0);
    finishOp(6'd5, 1'b0, 2'd0);
    tick();

    // signed multiply -3*3 from requester 1
    applyStimulus(2'b10, 16'h0, mkCmd(-3, 3, 3), 1'b1);
    waitGrant(1);
    finishOp(6'b110111, 1'b0, 2'd1);
    tick();

    // both requesters continuously valid
    gntLog.delete();
    gntCyc.delete();
    applyStimulus(2'b11, mkCmd(1, 1, 2), mkCmd(2, -1, 3), 1'b1);
    for (int k = 0; k < 60 && gntLog.size() < 4; k++) @(posedge clk);
    #1;
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
    checkOutput("contention_grants", 32'(gntLog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gntLog.size()) checkOutput($sformatf("grant_order%0d", i), 32'(gntLog[i]), 32'(expOrder[i]));
    end
    if (gntCyc.size() >= 2) checkOutput("grant_gap", 32'(gntCyc[1] - gntCyc[0]), 32'(ALSU_LAT + 3));
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("drain", 32'(found), 32'd1);
    tick();

    // invalid opcode 6
    applyStimulus(2'b01, mkCmd(1, 1, 6), 16'h0, 1'b1);
    waitGrant(0);
    finishOp(6'd0, 1'b1, 2'd0);
    tick();

    // response held off for 5 cycles while requester 0 waits
    applyStimulus(2'b10, 16'h0, mkCmd(1, 2, 2), 1'b0);
    waitGrant(1);
    finishOp(6'd3, 1'b0, 2'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      applyStimulus(2'b01, mkCmd(0, 1, 2), 16'h0, 1'b0);
      @(negedge clk);
      checkOutput("bp_valid", 32'(resp_valid), 32'd1);
      checkOutput("bp_data", 32'(resp_data), 32'd3);
      checkOutput("bp_busy", 32'(busy), 32'd1);
      checkOutput("bp_ready", 32'(req_ready), 32'd0);
    end
    tick();
    resp_ready = 1'b1;
    relCyc = cyc;
    gntLog.delete();
    gntCyc.delete();
    waitGrant(0);
    checkOutput("bp_next_grant", 32'((gntCyc.size() > 0) ? gntCyc[0] : -1), 32'(relCyc + 1));
    finishOp(6'd1, 1'b0, 2'd0);
    tick();

    // reset while waiting on the ALSU
    applyStimulus(2'b01, mkCmd(1, 1, 2), 16'h0, 1'b1);
    waitGrant(0);
    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(2'b11, mkCmd(2, 2, 2), mkCmd(1, 1, 1), 1'b1);
    @(negedge clk);
    checkOutput("rst_grant", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    tick();
    finishOp(6'd4, 1'b0, 2'd0);
    tick();

    applyStimulus(2'b00, 16'h0, 16'h0, 1'b1);
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
